// File: rtl/vu_enq_issue_ctrl.sv
// Issue controller: all-or-nothing enqueue into cmdq / ximm1q using per-queue credits,
// with a DRAIN mode. Optional replay statistics counter enabled by `define ISSUE_STATS_EN.
module vu_enq_issue_ctrl #(
  parameter int CMD_W   = 32,
  parameter int IMM_W   = 64,
  parameter int CMDQ_D  = 4,
  parameter int XIMMQ_D = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_valid,
  input  logic             io_sigs_enq_cmdq,
  input  logic             io_sigs_enq_ximm1q,
  input  logic [CMD_W-1:0] io_cmd,
  input  logic [IMM_W-1:0] io_imm,
  output logic             io_replay,
  output logic             io_cmdq_valid,
  output logic [CMD_W-1:0] io_cmdq_bits,
  output logic             io_ximm1q_valid,
  output logic [IMM_W-1:0] io_ximm1q_bits,
  input  logic             io_cmdq_deq,
  input  logic             io_ximm1q_deq,
  input  logic             io_drain,
  output logic             io_idle,
  output logic             io_dbg_drain
`ifdef ISSUE_STATS_EN
  ,
  output logic [15:0]      io_replay_cnt
`endif
);

  // Handshake: io_valid is a single-cycle offer. The instruction is taken in the same
  // cycle unless io_replay is high; a replayed instruction must be re-presented later.
  // io_*_valid are one-cycle enqueue strobes; io_*_deq return one credit each.

  localparam int CCW = $clog2(CMDQ_D + 1);
  localparam int XCW = $clog2(XIMMQ_D + 1);
  localparam logic [CCW-1:0] CMD_FULL = CCW'(CMDQ_D);
  localparam logic [XCW-1:0] IMM_FULL = XCW'(XIMMQ_D);

  typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CCW-1:0]   cmdq_cred_q, cmdq_cred_d;
  logic [XCW-1:0]   ximm_cred_q, ximm_cred_d;
  logic             cmdq_valid_q, cmdq_valid_d;
  logic             ximm_valid_q, ximm_valid_d;
  logic [CMD_W-1:0] cmdq_bits_q, cmdq_bits_d;
  logic [IMM_W-1:0] ximm_bits_q, ximm_bits_d;

  logic blk;
  logic accept;
  logic cmd_take;
  logic imm_take;
  logic idle;

  always_comb begin
    // A drain request blocks issue in the very cycle it is raised, not one cycle later.
    blk      = (io_sigs_enq_cmdq   && (cmdq_cred_q == '0)) ||
               (io_sigs_enq_ximm1q && (ximm_cred_q == '0)) ||
               (state_q == ST_DRAIN) || io_drain;
    accept   = io_valid && !blk;
    cmd_take = accept && io_sigs_enq_cmdq;
    imm_take = accept && io_sigs_enq_ximm1q;
    idle     = (cmdq_cred_q == CMD_FULL) && (ximm_cred_q == IMM_FULL) &&
               !cmdq_valid_q && !ximm_valid_q;
  end

  always_comb begin
    cmdq_cred_d = cmdq_cred_q;
    unique case ({cmd_take, io_cmdq_deq})
      2'b10:   cmdq_cred_d = cmdq_cred_q - 1'b1;
      // A credit return with nothing outstanding is dropped instead of wrapping.
      2'b01:   cmdq_cred_d = (cmdq_cred_q == CMD_FULL) ? cmdq_cred_q : cmdq_cred_q + 1'b1;
      default: cmdq_cred_d = cmdq_cred_q;
    endcase

    ximm_cred_d = ximm_cred_q;
    unique case ({imm_take, io_ximm1q_deq})
      2'b10:   ximm_cred_d = ximm_cred_q - 1'b1;
      2'b01:   ximm_cred_d = (ximm_cred_q == IMM_FULL) ? ximm_cred_q : ximm_cred_q + 1'b1;
      default: ximm_cred_d = ximm_cred_q;
    endcase
  end

  always_comb begin
    cmdq_valid_d = cmd_take;
    ximm_valid_d = imm_take;
    cmdq_bits_d  = cmd_take ? io_cmd : cmdq_bits_q;
    ximm_bits_d  = imm_take ? io_imm : ximm_bits_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (io_drain) state_d = ST_DRAIN;
      ST_DRAIN: if (!io_drain && idle) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      cmdq_cred_q  <= CMD_FULL;
      ximm_cred_q  <= IMM_FULL;
      cmdq_valid_q <= 1'b0;
      ximm_valid_q <= 1'b0;
      cmdq_bits_q  <= '0;
      ximm_bits_q  <= '0;
    end else begin
      state_q      <= state_d;
      cmdq_cred_q  <= cmdq_cred_d;
      ximm_cred_q  <= ximm_cred_d;
      cmdq_valid_q <= cmdq_valid_d;
      ximm_valid_q <= ximm_valid_d;
      cmdq_bits_q  <= cmdq_bits_d;
      ximm_bits_q  <= ximm_bits_d;
    end
  end

`ifdef ISSUE_STATS_EN
  logic [15:0] replay_cnt_q, replay_cnt_d;

  always_comb begin
    replay_cnt_d = replay_cnt_q;
    if (io_replay && (replay_cnt_q != 16'hFFFF)) replay_cnt_d = replay_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) replay_cnt_q <= '0;
    else       replay_cnt_q <= replay_cnt_d;
  end

  assign io_replay_cnt = replay_cnt_q;
`endif

  assign io_replay       = io_valid && blk;
  assign io_cmdq_valid   = cmdq_valid_q;
  assign io_cmdq_bits    = cmdq_bits_q;
  assign io_ximm1q_valid = ximm_valid_q;
  assign io_ximm1q_bits  = ximm_bits_q;
  assign io_idle         = idle;
  assign io_dbg_drain    = (state_q == ST_DRAIN);

endmodule

// File: tb/tb_vu_enq_issue_ctrl.sv
// Bench for vu_enq_issue_ctrl: directed scenarios followed by random traffic, all
// checked against a credit/queue reference model.
module tb_vu_enq_issue_ctrl;
  localparam int CMD_W   = 32;
  localparam int IMM_W   = 64;
  localparam int CMDQ_D  = 4;
  localparam int XIMMQ_D = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             io_valid, io_sigs_enq_cmdq, io_sigs_enq_ximm1q;
  logic [CMD_W-1:0] io_cmd;
  logic [IMM_W-1:0] io_imm;
  logic             io_replay, io_cmdq_valid, io_ximm1q_valid, io_idle, io_dbg_drain;
  logic [CMD_W-1:0] io_cmdq_bits;
  logic [IMM_W-1:0] io_ximm1q_bits;
  logic             io_cmdq_deq, io_ximm1q_deq, io_drain;
`ifdef ISSUE_STATS_EN
  logic [15:0]      io_replay_cnt;
`endif

  vu_enq_issue_ctrl #(
    .CMD_W(CMD_W), .IMM_W(IMM_W), .CMDQ_D(CMDQ_D), .XIMMQ_D(XIMMQ_D)
  ) dut (
    .clk(clk), .reset(reset),
    .io_valid(io_valid), .io_sigs_enq_cmdq(io_sigs_enq_cmdq),
    .io_sigs_enq_ximm1q(io_sigs_enq_ximm1q), .io_cmd(io_cmd), .io_imm(io_imm),
    .io_replay(io_replay),
    .io_cmdq_valid(io_cmdq_valid), .io_cmdq_bits(io_cmdq_bits),
    .io_ximm1q_valid(io_ximm1q_valid), .io_ximm1q_bits(io_ximm1q_bits),
    .io_cmdq_deq(io_cmdq_deq), .io_ximm1q_deq(io_ximm1q_deq),
    .io_drain(io_drain), .io_idle(io_idle), .io_dbg_drain(io_dbg_drain)
`ifdef ISSUE_STATS_EN
    , .io_replay_cnt(io_replay_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: free-slot counts, drain mode, last strobes and bits
  int               m_cc, m_ic, m_rc;
  bit               m_dr, m_cv, m_iv;
  logic [CMD_W-1:0] m_cb;
  logic [IMM_W-1:0] m_ib;
  logic [CMD_W-1:0] exp_q[$];
  logic [IMM_W-1:0] exp_imm_q[$];
  bit               last_rep;

  task automatic model_reset();
    m_cc = CMDQ_D; m_ic = XIMMQ_D; m_rc = 0;
    m_dr = 0; m_cv = 0; m_iv = 0; m_cb = '0; m_ib = '0;
    exp_q.delete(); exp_imm_q.delete();
  endtask

  task automatic check_post();
    check("cmdq_valid", 64'(io_cmdq_valid), 64'(m_cv));
    check("ximm_valid", 64'(io_ximm1q_valid), 64'(m_iv));
    check("cmdq_bits", 64'(io_cmdq_bits), 64'(m_cb));
    check("ximm_bits", io_ximm1q_bits, m_ib);
    check("dbg_drain", 64'(io_dbg_drain), 64'(m_dr));
`ifdef ISSUE_STATS_EN
    check("replay_cnt", 64'(io_replay_cnt), 64'(m_rc));
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    io_valid = 0; io_sigs_enq_cmdq = 0; io_sigs_enq_ximm1q = 0;
    io_cmd = '0; io_imm = '0; io_cmdq_deq = 0; io_ximm1q_deq = 0; io_drain = 0;
    repeat (2) @(negedge clk);
    model_reset();
    reset = 1'b0;
    #1;
    check("rst_replay", 64'(io_replay), 64'd0);
    check("rst_idle", 64'(io_idle), 64'd1);
    check_post();
  endtask

  // driver: one cycle of stimulus, checks before and after the clock edge
  task automatic step(input bit v, input bit c, input bit i,
                      input logic [CMD_W-1:0] cmd, input logic [IMM_W-1:0] imm,
                      input bit dc, input bit di, input bit dr);
    bit blk, er, acc, eidle;
    @(negedge clk);
    io_valid = v; io_sigs_enq_cmdq = c; io_sigs_enq_ximm1q = i;
    io_cmd = cmd; io_imm = imm; io_cmdq_deq = dc; io_ximm1q_deq = di; io_drain = dr;
    #2;
    blk   = (c && m_cc == 0) || (i && m_ic == 0) || m_dr || dr;
    er    = v && blk;
    acc   = v && !blk;
    eidle = (m_cc == CMDQ_D) && (m_ic == XIMMQ_D) && !m_cv && !m_iv;
    check("replay", 64'(io_replay), 64'(er));
    check("idle", 64'(io_idle), 64'(eidle));
    last_rep = io_replay;
    @(posedge clk);
    #1;
    if (!m_dr && dr) m_dr = 1;
    else if (m_dr && !dr && eidle) m_dr = 0;
    m_cc = m_cc - int'(acc && c) + int'(dc);
    if (m_cc > CMDQ_D) m_cc = CMDQ_D;
    m_ic = m_ic - int'(acc && i) + int'(di);
    if (m_ic > XIMMQ_D) m_ic = XIMMQ_D;
    m_cv = acc && c;
    m_iv = acc && i;
    if (m_cv) begin m_cb = cmd; exp_q.push_back(cmd); end
    if (m_iv) begin m_ib = imm; exp_imm_q.push_back(imm); end
    if (er && m_rc < 65535) m_rc++;
    check_post();
    if (io_cmdq_valid) begin
      if (exp_q.size() == 0) check("cmdq_sb_empty", 64'd1, 64'd0);
      else check("cmdq_sb", 64'(io_cmdq_bits), 64'(exp_q.pop_front()));
    end
    if (io_ximm1q_valid) begin
      if (exp_imm_q.size() == 0) check("ximm_sb_empty", 64'd1, 64'd0);
      else check("ximm_sb", io_ximm1q_bits, exp_imm_q.pop_front());
    end
  endtask

  task automatic idle_cyc(input bit dc, input bit di, input bit dr);
    step(0, 0, 0, '0, '0, dc, di, dr);
  endtask

  initial begin
    bit r_drain;
    reset = 1'b0;
    do_reset();

    // first enqueue with 1-cycle strobe latency
    step(1, 1, 0, 32'hA5, '0, 0, 0, 0);
    check("s1_replay", 64'(last_rep), 64'd0);
    check("s1_cvalid", 64'(io_cmdq_valid), 64'd1);
    check("s1_cbits", 64'(io_cmdq_bits), 64'hA5);

    // fill cmdq credits, fifth is replayed, credit return reopens
    for (int k = 0; k < 3; k++) step(1, 1, 0, 32'h100 + k, '0, 0, 0, 0);
    step(1, 1, 0, 32'hDEAD, '0, 0, 0, 0);
    check("s2_full_replay", 64'(last_rep), 64'd1);
    check("s2_no_strobe", 64'(io_cmdq_valid), 64'd0);
    idle_cyc(1, 0, 0);
    step(1, 1, 0, 32'hBEEF, '0, 0, 0, 0);
    check("s2_reopen", 64'(last_rep), 64'd0);

    // all-or-nothing: cmdq empty of credit, ximm at 2
    do_reset();
    step(1, 1, 1, 32'h1, 64'h11, 0, 0, 0);
    step(1, 1, 1, 32'h2, 64'h22, 0, 0, 0);
    step(1, 1, 0, 32'h3, '0, 0, 0, 0);
    step(1, 1, 0, 32'h4, '0, 0, 0, 0);
    step(1, 1, 1, 32'h5, 64'h55, 0, 0, 0);
    check("s3_atomic_replay", 64'(last_rep), 64'd1);
    check("s3_no_ximm", 64'(io_ximm1q_valid), 64'd0);
    step(1, 0, 1, '0, 64'h66, 0, 0, 0);
    step(1, 0, 1, '0, 64'h77, 0, 0, 0);
    check("s3_ximm_cred2", 64'(last_rep), 64'd0);
    step(1, 0, 1, '0, 64'h88, 0, 0, 0);
    check("s3_ximm_out", 64'(last_rep), 64'd1);

    // enqueue and deq together at one credit
    do_reset();
    for (int k = 0; k < 3; k++) step(1, 1, 0, 32'h200 + k, '0, 0, 0, 0);
    step(1, 1, 0, 32'h2FF, '0, 1, 0, 0);
    check("s4_same_cyc", 64'(io_cmdq_valid), 64'd1);
    step(1, 1, 0, 32'h300, '0, 0, 0, 0);
    check("s4_cred1_accept", 64'(last_rep), 64'd0);
    step(1, 1, 0, 32'h301, '0, 0, 0, 0);
    check("s4_cred0_replay", 64'(last_rep), 64'd1);

    // drain with two outstanding entries
    do_reset();
    step(1, 1, 0, 32'hC0, '0, 0, 0, 0);
    step(1, 0, 1, '0, 64'hC1, 0, 0, 0);
    step(1, 1, 0, 32'hC2, '0, 0, 0, 1);
    check("s5_drain_sameclk", 64'(last_rep), 64'd1);
    step(1, 0, 0, '0, '0, 0, 0, 1);
    check("s5_drain_replay", 64'(last_rep), 64'd1);
    check("s5_not_idle", 64'(io_idle), 64'd0);
    idle_cyc(1, 0, 1);
    idle_cyc(0, 1, 1);
    check("s5_idle", 64'(io_idle), 64'd1);
    idle_cyc(0, 0, 0);
    check("s5_run", 64'(io_dbg_drain), 64'd0);
    step(1, 1, 1, 32'hC3, 64'hC4, 0, 0, 0);
    check("s5_accept", 64'(last_rep), 64'd0);

`ifdef ISSUE_STATS_EN
    do_reset();
    step(1, 0, 0, '0, '0, 0, 0, 1);
    step(1, 0, 0, '0, '0, 0, 0, 1);
    step(1, 0, 0, '0, '0, 0, 0, 1);
    check("s6_cnt3", 64'(io_replay_cnt), 64'd3);
    do_reset();
    check("s6_cnt_rst", 64'(io_replay_cnt), 64'd0);
`endif

    // random traffic, including overflow deqs and drain sessions
    do_reset();
    r_drain = 0;
    for (int n = 0; n < 3000; n++) begin
      bit v, c, i, dc, di;
      v  = ($urandom_range(0, 3) != 0);
      c  = $urandom_range(0, 1);
      i  = $urandom_range(0, 1);
      dc = (m_cc < CMDQ_D)  ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      di = (m_ic < XIMMQ_D) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      if (!r_drain && $urandom_range(0, 49) == 0) r_drain = 1;
      else if (r_drain && $urandom_range(0, 7) == 0) r_drain = 0;
      if (n == 1500) begin
        reset = 1'b1;
        #1;
        model_reset();
        check("midrun_rst_idle", 64'(io_idle), 64'd1);
        @(negedge clk);
        reset = 1'b0;
      end
      step(v, c, i, $urandom, {$urandom, $urandom}, dc, di, r_drain);
    end

    check("sb_cmd_left", 64'(exp_q.size()), 64'd0);
    check("sb_imm_left", 64'(exp_imm_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

endmodule
